// File: rtl/twenty_bit_down_counter_pkg.sv
// Shared definitions for the 20-bit down-counter: operand width and FSM encoding.
// Optional feature macro used by the top level: SATURATE_EN (hold at zero on step underflow).
package twenty_bit_down_counter_pkg;

  localparam int WIDTH = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/twenty_bit_down_counter_dec.sv
// Combinational ripple decrementer built from a half-subtractor chain.
// bout is the borrow out of the top bit, i.e. high exactly when a == 0.
module twenty_bit_dec #(
  parameter int WIDTH = twenty_bit_down_counter_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] out,
  output logic             bout
);

  // b[gi] is the borrow into bit gi; subtracting one injects a borrow at bit 0.
  logic [WIDTH:0] b;

  assign b[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_half_sub
      assign out[gi]  = a[gi] ^ b[gi];
      assign b[gi+1]  = ~a[gi] & b[gi];
    end
  endgenerate

  assign bout = b[WIDTH];

endmodule

// File: rtl/twenty_bit_down_counter.sv
// Loadable 20-bit down-counter with run-to-zero countdown, single-step decrement and borrow-out.
// Define SATURATE_EN to make a step at zero hold the count at zero (borrow still pulses).
module twenty_bit_down_counter #(
  parameter int WIDTH = twenty_bit_down_counter_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             zero,
  output logic             borrow
);

  import twenty_bit_down_counter_pkg::*;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic             borrow_reg, borrow_next;
  logic [WIDTH-1:0] dec_out;
  logic             dec_bout;

  twenty_bit_dec #(.WIDTH(WIDTH)) u_dec (
    .a    (count_reg),
    .out  (dec_out),
    .bout (dec_bout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      borrow_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      borrow_reg <= borrow_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    borrow_next = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          count_next = load_val;
          state_next = (load_val != '0) ? COUNT : DONE;
        end else if (step) begin
          borrow_next = dec_bout;
`ifdef SATURATE_EN
          count_next  = dec_bout ? count_reg : dec_out;
`else
          count_next  = dec_out;
`endif
        end
      end
      COUNT: begin
        // Countdown leaves at 1, so the decrement here can never borrow.
        if (en) begin
          count_next = dec_out;
          if (dec_out == '0) state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_reg == COUNT);
    done   = (state_reg == DONE);
    zero   = (count_reg == '0);
    count  = count_reg;
    borrow = borrow_reg;
  end

endmodule
